wb_tag_target_buffer: RTL and testbench
=======================================

# wb_tag_target_buffer

- Registered, timeout-guarded buffer for one tagged Wishbone target port.
- Sits directly downstream of one target port of the tagged N×N interconnect and drives a single slow or untrusted target.
- Cuts all combinational paths between interconnect and target by holding one request and its response in registers.
- Converts a target that never responds into an error response after a bounded number of cycles, so the interconnect arbiter cannot lock up.

## Interface
Parameters:
- ADR_WIDTH, 32, address width
- DAT_WIDTH, 32, data width; a multiple of 8
- TGA_WIDTH, 4, address-tag width
- TGC_WIDTH, 4, cycle-tag width
- TGD_WIDTH, 4, data-tag width
- TIMEOUT_CYCLES, 256, maximum number of cycles tstb is held before an error is forced; 0 disables the timeout

Ports:
- clock  in  1  sole clock; all state changes on the rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- adr, dat_w, sel, we, cyc, stb, tga, tgc, tgd_w  in  ADR_WIDTH, DAT_WIDTH, DAT_WIDTH/8, 1, 1, 1, TGA_WIDTH, TGC_WIDTH, TGD_WIDTH  upstream request from the interconnect
- dat_r, tgd_r  out  DAT_WIDTH, TGD_WIDTH  upstream response data and data tag
- ack, err  out  1, 1  upstream response strobes
- tadr, tdat_w, tsel, twe, tcyc, tstb, ttga, ttgc, ttgd_w  out  same widths as the upstream request  registered request to the target
- tdat_r, ttgd_r, tack, terr  in  DAT_WIDTH, TGD_WIDTH, 1, 1  target response
- timeout  out  1  one-cycle pulse when a forced error is generated
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, REQ, RESP.
- **IDLE**
  - If cyc&&stb: capture adr, dat_w, sel, we, tga, tgc and tgd_w into the request registers.
  - Same edge: set tcyc and tstb to 1, clear the timeout counter, go to REQ.
  - Otherwise stay in IDLE.
- **REQ** (tcyc=tstb=1, request registers stable)
  - Upstream abort has priority: if cyc==0, clear tcyc/tstb, discard any response, go to IDLE; no ack or err is ever issued.
  - Else if tack or terr:
    - Capture tdat_r into the dat_r register and ttgd_r into the tgd_r register.
    - Set the response-error flag to terr; terr wins over a simultaneous tack.
    - Clear tcyc/tstb, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1:
    - Set the error flag, zero dat_r and tgd_r, pulse timeout.
    - Clear tcyc/tstb, go to RESP.
  - Else increment the counter.
- **RESP**
  - ack = cyc && !errflag; err = cyc && errflag. Both come from state, not from target inputs.
  - Exactly one cycle, then go to IDLE unconditionally.
- Upstream request inputs are ignored outside IDLE; the interconnect holds them stable until ack/err.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- tack/terr arriving in IDLE or RESP (spurious) are ignored.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - Every output goes to 0: dat_r, tgd_r, ack, err, all t* request outputs, timeout, busy.
  - Any in-flight transaction is dropped silently.

## Timing
- Upstream request sampled at edge E0 → tcyc/tstb high from E0 through the response edge.
- If the target acks in its first strobe cycle, RESP occupies the following cycle, so upstream ack is first visible 2 cycles after stb is first seen.
- Minimum issue rate is one transaction per 3 cycles: IDLE, REQ, RESP. The next request may be sampled in the cycle after RESP.
- Forced error: tstb is high for exactly TIMEOUT_CYCLES cycles. The error pulses in the next cycle, together with a one-cycle timeout pulse on the transition edge.
- All outputs are registers or decoded directly from state registers. There is no combinational path from any input to any output.

## Test plan
- **Write:** adr=0x2800_0010, dat_w=0xDEADBEEF, sel=0xF, we=1, tga=3, tgc=5. Target acks in the first REQ cycle.
  - tadr, tdat_w, ttga, ttgc match the request.
  - ack=1 for one cycle, 2 cycles after stb; err=0; busy=0 afterwards.
- **Read with tag:** target returns tdat_r=0x12345678, ttgd_r=0xA after 3 wait cycles.
  - dat_r=0x12345678, tgd_r=0xA with ack=1.
  - tstb is high for exactly 4 cycles.
- **Target error:** terr and tack asserted together → err=1, ack=0, timeout=0.
- **Timeout:** TIMEOUT_CYCLES=8 and the target is silent.
  - tstb is high for 8 cycles, then drops.
  - err=1 and timeout=1 in the next cycle, with dat_r=0.
  - A second request is then serviced normally.
- **Abort and reset:**
  - Upstream cyc drops in the 2nd REQ cycle → tcyc=0 next cycle; no ack/err even if tack arrives later.
  - reset_n pulsed low mid-REQ → all outputs 0 immediately; state is IDLE.
- **Back-to-back:** 4 reads with stb held continuously and an immediately-acking target → 4 acks spaced exactly 3 cycles apart, each carrying the correct data.

Source files
------------

// File: rtl/wb_tag_target_buffer.sv
// Registered, timeout-guarded buffer for one tagged Wishbone target port.
// Latency: ack/err two cycles after stb with an immediately acking target; at most one transaction per 3 cycles.
// Backpressure: upstream holds its request until ack/err. A silent target is answered with err after TIMEOUT_CYCLES strobe cycles.
//
// Ports:
//   clock, reset_n                       clock and asynchronous active-low reset
//   adr/dat_w/sel/we/cyc/stb/tga/tgc/tgd_w   upstream request from the interconnect
//   dat_r/tgd_r/ack/err                  registered upstream response
//   tadr/tdat_w/tsel/twe/tcyc/tstb/ttga/ttgc/ttgd_w  registered request to the target
//   tdat_r/ttgd_r/tack/terr              target response
//   timeout                              one-cycle pulse alongside a forced err
//   busy                                 high whenever a transaction is in flight
module wb_tag_target_buffer #(
  parameter int ADR_WIDTH      = 32,
  parameter int DAT_WIDTH      = 32,
  parameter int TGA_WIDTH      = 4,
  parameter int TGC_WIDTH      = 4,
  parameter int TGD_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clock,
  input  logic                   reset_n,
  // upstream request
  input  logic [ADR_WIDTH-1:0]   adr,
  input  logic [DAT_WIDTH-1:0]   dat_w,
  input  logic [DAT_WIDTH/8-1:0] sel,
  input  logic                   we,
  input  logic                   cyc,
  input  logic                   stb,
  input  logic [TGA_WIDTH-1:0]   tga,
  input  logic [TGC_WIDTH-1:0]   tgc,
  input  logic [TGD_WIDTH-1:0]   tgd_w,
  // upstream response
  output logic [DAT_WIDTH-1:0]   dat_r,
  output logic [TGD_WIDTH-1:0]   tgd_r,
  output logic                   ack,
  output logic                   err,
  // request to the target
  output logic [ADR_WIDTH-1:0]   tadr,
  output logic [DAT_WIDTH-1:0]   tdat_w,
  output logic [DAT_WIDTH/8-1:0] tsel,
  output logic                   twe,
  output logic                   tcyc,
  output logic                   tstb,
  output logic [TGA_WIDTH-1:0]   ttga,
  output logic [TGC_WIDTH-1:0]   ttgc,
  output logic [TGD_WIDTH-1:0]   ttgd_w,
  // target response
  input  logic [DAT_WIDTH-1:0]   tdat_r,
  input  logic [TGD_WIDTH-1:0]   ttgd_r,
  input  logic                   tack,
  input  logic                   terr,
  // status
  output logic                   timeout,
  output logic                   busy
);

  // A one-bit counter is kept when the timeout is disabled so the width never collapses to zero.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tadr    <= '0;
      tdat_w  <= '0;
      tsel    <= '0;
      twe     <= 1'b0;
      tcyc    <= 1'b0;
      tstb    <= 1'b0;
      ttga    <= '0;
      ttgc    <= '0;
      ttgd_w  <= '0;
      dat_r   <= '0;
      tgd_r   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      // ack/err/timeout are only ever raised on the edge entering RESP, so they
      // last exactly the single RESP cycle. cyc is known high on that edge
      // because an abort takes priority, which makes the registered strobes
      // equal to cyc-qualified decodes of the response flag.
      ack     <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cyc && stb) begin
            tadr   <= adr;
            tdat_w <= dat_w;
            tsel   <= sel;
            twe    <= we;
            ttga   <= tga;
            ttgc   <= tgc;
            ttgd_w <= tgd_w;
            tcyc   <= 1'b1;
            tstb   <= 1'b1;
            cnt    <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (!cyc) begin
            // upstream abandoned the cycle: drop it without any response
            tcyc  <= 1'b0;
            tstb  <= 1'b0;
            state <= IDLE;
          end else if (tack || terr) begin
            dat_r <= tdat_r;
            tgd_r <= ttgd_r;
            err   <= terr;
            ack   <= !terr;
            tcyc  <= 1'b0;
            tstb  <= 1'b0;
            state <= RESP;
          end else if (timeout_hit) begin
            dat_r   <= '0;
            tgd_r   <= '0;
            err     <= 1'b1;
            timeout <= 1'b1;
            tcyc    <= 1'b0;
            tstb    <= 1'b0;
            state   <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_tag_target_buffer.sv
module tb_wb_tag_target_buffer;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] adr = '0, dat_w = '0, tdat_r = '0;
  logic [3:0]  sel = '0, tga = '0, tgc = '0, tgd_w = '0, ttgd_r = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, tack = 1'b0, terr = 1'b0;
  logic [31:0] dat_r, tadr, tdat_w;
  logic [3:0]  tgd_r, tsel, ttga, ttgc, ttgd_w;
  logic        ack, err, twe, tcyc, tstb, timeout, busy;

  wb_tag_target_buffer #(
    .ADR_WIDTH(32), .DAT_WIDTH(32), .TGA_WIDTH(4), .TGC_WIDTH(4), .TGD_WIDTH(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .adr(adr), .dat_w(dat_w), .sel(sel), .we(we), .cyc(cyc), .stb(stb),
    .tga(tga), .tgc(tgc), .tgd_w(tgd_w),
    .dat_r(dat_r), .tgd_r(tgd_r), .ack(ack), .err(err),
    .tadr(tadr), .tdat_w(tdat_w), .tsel(tsel), .twe(twe), .tcyc(tcyc), .tstb(tstb),
    .ttga(ttga), .ttgc(ttgc), .ttgd_w(ttgd_w),
    .tdat_r(tdat_r), .ttgd_r(ttgd_r), .tack(tack), .terr(terr),
    .timeout(timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // One upstream request plus how the emulated target behaves.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [3:0]  tga;
    logic [3:0]  tgc;
    logic [3:0]  tgd;
    int          wt;      // wait cycles before the target answers
    logic        silent;  // target never answers
    logic        use_err; // target answers with tack and terr together
    logic [31:0] rdat;
    logic [3:0]  rtgd;
  } txn_t;

  // Observable outcome of one transaction.
  typedef struct {
    logic        ack;
    logic        err;
    logic        tmo;
    logic [31:0] dat;
    logic [3:0]  tgd;
    int          strobes; // cycles tstb was seen high
    int          lat;     // cycles from request presentation to response visible
  } res_t;

  typedef struct {
    txn_t t;
    res_t e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: the target answers after wt waits unless the
  // timeout window of TMO strobe cycles runs out first.
  function automatic res_t model(input txn_t t);
    res_t e;
    if (t.silent || (t.wt + 1 > TMO)) begin
      e.ack = 1'b0; e.err = 1'b1; e.tmo = 1'b1; e.dat = '0; e.tgd = '0;
      e.strobes = TMO; e.lat = TMO + 1;
    end else begin
      e.ack = !t.use_err; e.err = t.use_err; e.tmo = 1'b0; e.dat = t.rdat; e.tgd = t.rtgd;
      e.strobes = t.wt + 1; e.lat = t.wt + 2;
    end
    return e;
  endfunction

  task automatic run_txn(input string name, input txn_t t, output res_t r);
    int  strobes = 0;
    int  lat = 0;
    bit  done = 0;
    bit  first = 1;
    r.ack = 0; r.err = 0; r.tmo = 0; r.dat = '0; r.tgd = '0; r.strobes = 0; r.lat = 0;
    adr = t.adr; dat_w = t.dat; sel = t.sel; we = t.we;
    tga = t.tga; tgc = t.tgc; tgd_w = t.tgd;
    tdat_r = t.rdat; ttgd_r = t.rtgd; tack = 0; terr = 0;
    cyc = 1; stb = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clock); #1;
      lat++;
      if (ack || err) begin
        r.ack = ack; r.err = err; r.tmo = timeout; r.dat = dat_r; r.tgd = tgd_r;
        r.strobes = strobes; r.lat = lat;
        done = 1;
        cyc = 0; stb = 0; tack = 0; terr = 0;
      end else if (tstb) begin
        strobes++;
        if (first) begin
          first = 0;
          chk({name, ".tadr"}, tadr, t.adr);
          chk({name, ".tdat_w"}, tdat_w, t.dat);
          chk({name, ".tsel"}, tsel, t.sel);
          chk({name, ".twe"}, twe, t.we);
          chk({name, ".ttga"}, ttga, t.tga);
          chk({name, ".ttgc"}, ttgc, t.tgc);
          chk({name, ".ttgd_w"}, ttgd_w, t.tgd);
          chk({name, ".tcyc"}, tcyc, 1);
          chk({name, ".busy"}, busy, 1);
        end
        if (!t.silent && strobes == t.wt + 1) begin
          tack = 1; terr = t.use_err;
        end else begin
          tack = 0; terr = 0;
        end
      end else begin
        tack = 0; terr = 0;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s.no_response: got none expected ack or err within 60 cycles", name);
      cyc = 0; stb = 0; tack = 0; terr = 0;
    end
    // response strobes last one cycle, then the buffer is idle again
    @(posedge clock); #1;
    chk({name, ".post_ack"}, ack, 0);
    chk({name, ".post_err"}, err, 0);
    chk({name, ".post_timeout"}, timeout, 0);
    chk({name, ".post_busy"}, busy, 0);
  endtask

  task automatic cmp_res(input string name, input res_t g, input res_t e);
    chk({name, ".ack"}, g.ack, e.ack);
    chk({name, ".err"}, g.err, e.err);
    chk({name, ".timeout"}, g.tmo, e.tmo);
    chk({name, ".dat_r"}, g.dat, e.dat);
    chk({name, ".tgd_r"}, g.tgd, e.tgd);
    chk({name, ".strobes"}, g.strobes, e.strobes);
    chk({name, ".latency"}, g.lat, e.lat);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".dat_r"}, dat_r, 0);
    chk({name, ".tgd_r"}, tgd_r, 0);
    chk({name, ".ack"}, ack, 0);
    chk({name, ".err"}, err, 0);
    chk({name, ".tadr"}, tadr, 0);
    chk({name, ".tdat_w"}, tdat_w, 0);
    chk({name, ".tsel"}, tsel, 0);
    chk({name, ".twe"}, twe, 0);
    chk({name, ".tcyc"}, tcyc, 0);
    chk({name, ".tstb"}, tstb, 0);
    chk({name, ".ttga"}, ttga, 0);
    chk({name, ".ttgc"}, ttgc, 0);
    chk({name, ".ttgd_w"}, ttgd_w, 0);
    chk({name, ".timeout"}, timeout, 0);
    chk({name, ".busy"}, busy, 0);
  endtask

  localparam int NV = 7;
  vec_t vt[NV];

  initial begin
    res_t        got;
    txn_t        rt;
    logic [31:0] bd[4];
    int          ack_at[$];
    int          cyc_n;
    int          idx;

    //          adr           dat           sel   we  tga tgc tgd wt silent err rdat          rtgd
    vt[0].t = '{32'h2800_0010, 32'hDEADBEEF, 4'hF, 1'b1, 4'd3, 4'd5, 4'd0, 0, 1'b0, 1'b0, 32'h0000_0000, 4'h0};
    vt[0].e = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 1, 2};
    vt[1].t = '{32'h2800_0020, 32'h0000_0000, 4'hF, 1'b0, 4'd1, 4'd2, 4'd0, 3, 1'b0, 1'b0, 32'h1234_5678, 4'hA};
    vt[1].e = '{1'b1, 1'b0, 1'b0, 32'h1234_5678, 4'hA, 4, 5};
    vt[2].t = '{32'h2800_0030, 32'h0BAD_0BAD, 4'h3, 1'b1, 4'd7, 4'd1, 4'd9, 0, 1'b0, 1'b1, 32'h0000_0055, 4'h2};
    vt[2].e = '{1'b0, 1'b1, 1'b0, 32'h0000_0055, 4'h2, 1, 2};
    vt[3].t = '{32'h2800_0040, 32'h0000_0000, 4'hF, 1'b0, 4'd0, 4'd0, 4'd0, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'hF};
    vt[3].e = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'h0, 8, 9};
    vt[4].t = '{32'h2800_0050, 32'h0000_0000, 4'hF, 1'b0, 4'd2, 4'd4, 4'd6, 1, 1'b0, 1'b0, 32'hCAFE_F00D, 4'h3};
    vt[4].e = '{1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 4'h3, 2, 3};
    // answer in the last strobe cycle of the window still wins over the timeout
    vt[5].t = '{32'h2800_0060, 32'h0000_0000, 4'hF, 1'b0, 4'd0, 4'd0, 4'd0, 7, 1'b0, 1'b0, 32'hA5A5_5A5A, 4'h5};
    vt[5].e = '{1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A, 4'h5, 8, 9};
    // one cycle too late: the timeout fires first
    vt[6].t = '{32'h2800_0070, 32'h0000_0000, 4'hF, 1'b0, 4'd0, 4'd0, 4'd0, 8, 1'b0, 1'b0, 32'h5A5A_A5A5, 4'h6};
    vt[6].e = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'h0, 8, 9};

    // reset state
    #12;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk_all_zero("after_reset");

    // directed table
    for (int i = 0; i < NV; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i].t, got);
      cmp_res($sformatf("vec%0d", i), got, vt[i].e);
    end

    // abort in the second REQ cycle; a late tack must not produce a response
    adr = 32'h3000_0000; dat_w = 32'h1; sel = 4'hF; we = 1; tga = 1; tgc = 1; tgd_w = 1;
    cyc = 1; stb = 1;
    @(posedge clock); #1;
    chk("abort.tstb_req1", tstb, 1);
    @(posedge clock); #1;
    chk("abort.tstb_req2", tstb, 1);
    cyc = 0; stb = 0;
    @(posedge clock); #1;
    chk("abort.tcyc", tcyc, 0);
    chk("abort.tstb", tstb, 0);
    chk("abort.busy", busy, 0);
    tack = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      chk($sformatf("abort.ack%0d", c), ack, 0);
      chk($sformatf("abort.err%0d", c), err, 0);
    end
    tack = 0;

    // reset pulse while a request is outstanding
    adr = 32'h4000_0004; dat_w = 32'h7777_7777; cyc = 1; stb = 1;
    @(posedge clock); #1;
    chk("rst_mid.tstb_before", tstb, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    cyc = 0; stb = 0;
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid.busy_after", busy, 0);
    chk("rst_mid.ack_after", ack, 0);
    run_txn("post_rst", vt[4].t, got);
    cmp_res("post_rst", got, vt[4].e);

    // back-to-back reads, stb held, target acks on the first strobe
    bd[0] = 32'h1111_0001; bd[1] = 32'h2222_0002; bd[2] = 32'h3333_0003; bd[3] = 32'h4444_0004;
    idx = 0; cyc_n = 0;
    adr = 32'h0000_0100; we = 0; tdat_r = bd[0]; ttgd_r = 4'h0;
    cyc = 1; stb = 1; tack = 0; terr = 0;
    for (int c = 0; c < 30 && ack_at.size() < 4; c++) begin
      @(posedge clock); #1;
      cyc_n++;
      if (tstb) chk($sformatf("b2b.tadr%0d", idx), tadr, 32'h0000_0100 + 32'(idx));
      if (ack) begin
        chk($sformatf("b2b.dat%0d", idx), dat_r, bd[idx]);
        ack_at.push_back(cyc_n);
        idx++;
        if (idx < 4) begin
          adr = 32'h0000_0100 + 32'(idx);
          tdat_r = bd[idx];
        end
      end
      tack = tstb;
    end
    cyc = 0; stb = 0; tack = 0;
    chk("b2b.ack_count", ack_at.size(), 4);
    if (ack_at.size() == 4) begin
      chk("b2b.first_ack", ack_at[0], 2);
      for (int i = 1; i < 4; i++) chk($sformatf("b2b.spacing%0d", i), ack_at[i] - ack_at[i-1], 3);
    end
    @(posedge clock); #1;
    chk("b2b.busy_end", busy, 0);

    // randomized transactions against the transaction-level model
    for (int i = 0; i < 24; i++) begin
      rt.adr = $urandom; rt.dat = $urandom; rt.sel = 4'($urandom); rt.we = 1'($urandom);
      rt.tga = 4'($urandom); rt.tgc = 4'($urandom); rt.tgd = 4'($urandom);
      rt.wt = $urandom_range(0, 10);
      rt.silent = ($urandom_range(0, 7) == 0);
      rt.use_err = ($urandom_range(0, 3) == 0);
      rt.rdat = $urandom; rt.rtgd = 4'($urandom);
      run_txn($sformatf("rnd%0d", i), rt, got);
      cmp_res($sformatf("rnd%0d", i), got, model(rt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
